// File: rtl/spi_slave_shifter_if.sv
// Parallel byte interface between the SPI slave shifter and its register block.
interface spi_slave_shifter_if;
  logic [7:0] tx_data;
  logic       tx_load;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_empty;
  logic       underrun;
  logic       busy;

  modport master (output tx_data, tx_load,
                  input  rx_data, rx_valid, tx_empty, underrun, busy);
  modport slave  (input  tx_data, tx_load,
                  output rx_data, rx_valid, tx_empty, underrun, busy);
endinterface

// File: rtl/spi_slave_shifter.sv
// SPI peripheral shift engine: SCLK/SS/MOSI oversampled in PCLK, byte-wide
// rx/tx with a single transmit holding register and underrun fill.
module spi_slave_shifter #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_TX     = 8'h00
) (
  input  logic PCLK,
  input  logic PRESET_n,
  input  logic sclk_i,
  input  logic ss_n_i,
  input  logic mosi_i,
  input  logic cpol_i,
  input  logic cpha_i,
  input  logic lsbfe_i,
  output logic miso_o,
  output logic miso_oe_o,
  spi_slave_shifter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sy, ss_sy, mosi_sy;
  logic sclk_s, ss_s, mosi_s, sclk_d, ss_d;
  logic ss_rise, ss_fall, smp_edge, sft_edge;
  logic do_reload, do_sample, do_shift;
  logic [7:0] tx_sr, rx_sr, hold, rx_data_q, reload_byte, rx_next;
  logic [2:0] bit_cnt;
  logic miso_q, oe_q, busy_q, rx_done, rx_valid_q, underrun_q, tx_empty_q;

  function automatic logic first_bit(input logic [7:0] v, input logic lsb);
    return lsb ? v[0] : v[7];
  endfunction

  function automatic logic [7:0] advance(input logic [7:0] v, input logic lsb);
    return lsb ? {1'b0, v[7:1]} : {v[6:0], 1'b0};
  endfunction

  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) begin
      sclk_sy <= '0;
      ss_sy   <= '0;
      mosi_sy <= '0;
      sclk_d  <= 1'b0;
      ss_d    <= 1'b0;
    end else begin
      sclk_sy <= {sclk_sy[SYNC_STAGES-2:0], sclk_i};
      ss_sy   <= {ss_sy[SYNC_STAGES-2:0], ss_n_i};
      mosi_sy <= {mosi_sy[SYNC_STAGES-2:0], mosi_i};
      sclk_d  <= sclk_s;
      ss_d    <= ss_s;
    end
  end

  assign sclk_s   = sclk_sy[SYNC_STAGES-1];
  assign ss_s     = ss_sy[SYNC_STAGES-1];
  assign mosi_s   = mosi_sy[SYNC_STAGES-1];
  assign ss_rise  = ss_s & ~ss_d;
  assign ss_fall  = ~ss_s & ss_d;
  // Modes 0/3 sample on rising SCLK, modes 1/2 on falling; shift on the other edge.
  assign smp_edge = (cpol_i == cpha_i) ? (sclk_s & ~sclk_d) : (~sclk_s & sclk_d);
  assign sft_edge = (cpol_i == cpha_i) ? (~sclk_s & sclk_d) : (sclk_s & ~sclk_d);

  assign reload_byte = tx_empty_q ? IDLE_TX : hold;
  assign rx_next     = lsbfe_i ? {mosi_s, rx_sr[7:1]} : {rx_sr[6:0], mosi_s};

  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    do_reload = 1'b0;
    do_sample = 1'b0;
    do_shift  = 1'b0;
    case (state_q)
      IDLE:  if (ss_fall) state_d = LOAD;
      LOAD:  begin
        do_reload = 1'b1;
        state_d   = SHIFT;
      end
      SHIFT: if (!ss_s) begin
        do_sample = smp_edge;
        do_shift  = sft_edge;
        do_reload = smp_edge && (bit_cnt == 3'd7);
      end
      default: state_d = IDLE;
    endcase
    if (ss_rise) begin
      state_d   = IDLE;
      do_reload = 1'b0;
      do_sample = 1'b0;
      do_shift  = 1'b0;
    end
  end

  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) begin
      tx_sr      <= '0;
      rx_sr      <= '0;
      hold       <= '0;
      rx_data_q  <= '0;
      bit_cnt    <= '0;
      miso_q     <= 1'b0;
      oe_q       <= 1'b0;
      busy_q     <= 1'b0;
      rx_done    <= 1'b0;
      rx_valid_q <= 1'b0;
      underrun_q <= 1'b0;
      tx_empty_q <= 1'b1;
    end else begin
      underrun_q <= 1'b0;
      rx_done    <= 1'b0;
      rx_valid_q <= rx_done;
      if (ss_rise) begin
        busy_q  <= 1'b0;
        oe_q    <= 1'b0;
        miso_q  <= 1'b0;
        bit_cnt <= '0;
      end else begin
        if (state_q == IDLE && ss_fall) begin
          busy_q <= 1'b1;
          oe_q   <= 1'b1;
        end
        if (do_reload) begin
          underrun_q <= tx_empty_q;
          tx_empty_q <= 1'b1;
          // With CPHA=0 the first bit must already be on the wire before the first edge.
          if (state_q == LOAD && !cpha_i) begin
            miso_q <= first_bit(reload_byte, lsbfe_i);
            tx_sr  <= advance(reload_byte, lsbfe_i);
          end else begin
            tx_sr <= reload_byte;
          end
        end else if (do_shift) begin
          miso_q <= first_bit(tx_sr, lsbfe_i);
          tx_sr  <= advance(tx_sr, lsbfe_i);
        end
        if (state_q == LOAD) bit_cnt <= '0;
        if (do_sample) begin
          rx_sr   <= rx_next;
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            rx_data_q <= rx_next;
            rx_done   <= 1'b1;
          end
        end
      end
      // A new write lands after any same-cycle reload has taken the old byte.
      if (bus.tx_load) begin
        hold       <= bus.tx_data;
        tx_empty_q <= 1'b0;
      end
    end
  end

  assign miso_o       = miso_q;
  assign miso_oe_o    = oe_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.tx_empty = tx_empty_q;
  assign bus.underrun = underrun_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_spi_slave_shifter.sv
// Directed bench for spi_slave_shifter: acts as SPI master across modes 0/1/3,
// covering back-to-back bytes, SS abort, underrun and mid-transfer reset.
module tb_spi_slave_shifter;
  localparam int HALF = 50;

  logic PCLK = 1'b0;
  logic PRESET_n = 1'b0;
  logic sclk = 1'b0, ss_n = 1'b1, mosi = 1'b0;
  logic cpol = 1'b0, cpha = 1'b0, lsbfe = 1'b0;
  logic miso, miso_oe;
  int checks = 0, errors = 0;
  int rx_pulses = 0, un_pulses = 0;
  logic [7:0] last_rx = 8'h00;
  logic [7:0] din;
  int rx_base, un_base;

  spi_slave_shifter_if bus();

  spi_slave_shifter #(.SYNC_STAGES(2), .IDLE_TX(8'h00)) dut (
    .PCLK(PCLK), .PRESET_n(PRESET_n), .sclk_i(sclk), .ss_n_i(ss_n), .mosi_i(mosi),
    .cpol_i(cpol), .cpha_i(cpha), .lsbfe_i(lsbfe),
    .miso_o(miso), .miso_oe_o(miso_oe), .bus(bus)
  );

  always #5 PCLK = ~PCLK;

  always @(negedge PCLK) begin
    if (bus.rx_valid) begin
      rx_pulses++;
      last_rx = bus.rx_data;
    end
    if (bus.underrun) un_pulses++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_tx(input logic [7:0] b);
    @(negedge PCLK);
    bus.tx_data = b;
    bus.tx_load = 1'b1;
    @(negedge PCLK);
    bus.tx_load = 1'b0;
  endtask

  task automatic ss_low();
    @(negedge PCLK);
    ss_n = 1'b0;
    #100;
  endtask

  task automatic ss_high();
    #100;
    ss_n = 1'b1;
    #100;
  endtask

  task automatic set_mode(input logic pol, input logic pha, input logic lsb);
    cpol = pol; cpha = pha; lsbfe = lsb; sclk = pol;
    #100;
  endtask

  // Master side: shifts dout on MOSI, captures MISO into din at its sample edges.
  task automatic xfer(input logic [7:0] dout, input int nbits, output logic [7:0] dmiso);
    dmiso = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      int idx;
      idx = lsbfe ? i : 7 - i;
      if (!cpha) begin
        mosi = dout[idx]; #HALF;
        sclk = ~cpol; dmiso[idx] = miso; #HALF;
        sclk = cpol;
      end else begin
        sclk = ~cpol; mosi = dout[idx]; #HALF;
        sclk = cpol; dmiso[idx] = miso; #HALF;
      end
    end
  endtask

  task automatic wait_rx(input int target);
    for (int k = 0; k < 40 && rx_pulses < target; k++) @(negedge PCLK);
  endtask

  initial begin
    bus.tx_data = 8'h00;
    bus.tx_load = 1'b0;
    #12;
    check("rst_miso", miso, 0);
    check("rst_oe", miso_oe, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_rxv", bus.rx_valid, 0);
    check("rst_under", bus.underrun, 0);
    check("rst_rxdata", bus.rx_data, 8'h00);
    check("rst_empty", bus.tx_empty, 1);
    @(negedge PCLK);
    PRESET_n = 1'b1;
    #100;

    // Mode 0, MSB first
    set_mode(1'b0, 1'b0, 1'b0);
    load_tx(8'h3C);
    check("t1_empty_after_load", bus.tx_empty, 0);
    rx_base = rx_pulses; un_base = un_pulses;
    ss_low();
    check("t1_busy", bus.busy, 1);
    check("t1_oe", miso_oe, 1);
    check("t1_empty_after_ld", bus.tx_empty, 1);
    check("t1_no_under", un_pulses - un_base, 0);
    xfer(8'hA5, 8, din);
    wait_rx(rx_base + 1);
    repeat (10) @(negedge PCLK);
    check("t1_rx_pulses", rx_pulses - rx_base, 1);
    check("t1_rx", last_rx, 8'hA5);
    check("t1_miso", din, 8'h3C);
    ss_high();
    check("t1_oe_off", miso_oe, 0);
    check("t1_busy_off", bus.busy, 0);

    // Mode 3, LSB first
    set_mode(1'b1, 1'b1, 1'b1);
    load_tx(8'h81);
    rx_base = rx_pulses;
    ss_low();
    check("t2_miso_pre", miso, 0);
    xfer(8'h0F, 8, din);
    wait_rx(rx_base + 1);
    check("t2_rx_pulses", rx_pulses - rx_base, 1);
    check("t2_rx", bus.rx_data, 8'h0F);
    check("t2_miso", din, 8'h81);
    ss_high();

    // Mode 1, two back-to-back bytes
    set_mode(1'b0, 1'b1, 1'b0);
    load_tx(8'h11);
    rx_base = rx_pulses; un_base = un_pulses;
    ss_low();
    load_tx(8'h22);
    check("t3_empty", bus.tx_empty, 0);
    xfer(8'hC3, 8, din);
    wait_rx(rx_base + 1);
    check("t3_rx1", last_rx, 8'hC3);
    check("t3_miso1", din, 8'h11);
    check("t3_no_under", un_pulses - un_base, 0);
    xfer(8'h5A, 8, din);
    wait_rx(rx_base + 2);
    check("t3_rx_pulses", rx_pulses - rx_base, 2);
    check("t3_rx2", last_rx, 8'h5A);
    check("t3_miso2", din, 8'h22);
    ss_high();

    // SS abort after three bits
    set_mode(1'b0, 1'b0, 1'b0);
    rx_base = rx_pulses;
    ss_low();
    xfer(8'hFF, 3, din);
    ss_high();
    repeat (10) @(negedge PCLK);
    check("t4_no_rxv", rx_pulses - rx_base, 0);
    check("t4_rx_kept", bus.rx_data, 8'h5A);
    check("t4_oe_off", miso_oe, 0);
    check("t4_busy_off", bus.busy, 0);
    ss_low();
    xfer(8'h12, 8, din);
    wait_rx(rx_base + 1);
    check("t4_rx", last_rx, 8'h12);
    ss_high();

    // Underrun with empty holding register
    check("t5_empty_pre", bus.tx_empty, 1);
    un_base = un_pulses;
    ss_low();
    check("t5_under_load", un_pulses - un_base, 1);
    xfer(8'h33, 8, din);
    check("t5_miso_zero", din, 8'h00);
    check("t5_empty", bus.tx_empty, 1);
    ss_high();

    // Reset in the middle of a byte
    rx_base = rx_pulses;
    ss_low();
    xfer(8'hF0, 4, din);
    PRESET_n = 1'b0;
    #1;
    check("t6_busy", bus.busy, 0);
    check("t6_oe", miso_oe, 0);
    check("t6_miso", miso, 0);
    check("t6_rxdata", bus.rx_data, 8'h00);
    check("t6_empty", bus.tx_empty, 1);
    check("t6_rxv", bus.rx_valid, 0);
    #20;
    PRESET_n = 1'b1;
    #50;
    check("t6_no_resume", bus.busy, 0);
    ss_high();
    ss_low();
    xfer(8'h96, 8, din);
    wait_rx(rx_base + 1);
    check("t6_rx_pulses", rx_pulses - rx_base, 1);
    check("t6_rx", last_rx, 8'h96);
    ss_high();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
